// File: rtl/fifo_pkg.sv
// Shared definitions for sync_fifo: default sizes, pointer-width helper and the sticky error record.
package fifo_pkg;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a producer/consumer (master) and sync_fifo (slave).
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
);

  localparam int unsigned LVL_W = ptr_w(DEPTH) + 1;

  logic              wr_en;
  logic [DWIDTH-1:0] din;
  logic              rd_en;
  logic              flush;
  logic              clr_err;
  logic [DWIDTH-1:0] dout;
  logic              dout_vld;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, flush, clr_err,
    input  dout, dout_vld, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, flush, clr_err,
    output dout, dout_vld, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, read port registered (REG_RD=1) or combinational.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter bit          REG_RD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DWIDTH-1:0]        rdata
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [DWIDTH-1:0] rdata_d;
      logic [DWIDTH-1:0] rdata_q;

      always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_comb_rd
      logic unused_c;
      assign unused_c = rst ^ re;
      assign rdata    = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level count, almost flags, flush and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is registered-read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int unsigned AW    = ptr_w(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0] level_d,  level_q;
  logic             empty_d,  empty_q;
  logic             full_d,   full_q;
  logic             aempty_d, aempty_q;
  logic             afull_d,  afull_q;
  logic             dout_vld_d, dout_vld_q;
  fifo_err_t        err_d,    err_q;
  logic             wr_acc_c, rd_acc_c;
  logic             ram_we_c, ram_re_c;
  logic [DWIDTH-1:0] ram_rdata;

  // Acceptance uses the flags registered at the start of the cycle; flush overrides both ports.
  always_comb begin
    wr_acc_c   = bus.wr_en && !full_q;
    rd_acc_c   = bus.rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    err_d      = err_q;
    dout_vld_d = 1'b0;

    if (bus.clr_err) err_d = '0;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc_c, rd_acc_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (bus.wr_en && full_q)  err_d.overflow  = 1'b1;
      if (bus.rd_en && empty_q) err_d.underflow = 1'b1;
      dout_vld_d = rd_acc_c;
    end

    empty_d  = (level_d == '0);
    full_d   = (level_d == LVL_W'(DEPTH));
    aempty_d = (level_d <= LVL_W'(AEMPTY_TH));
    afull_d  = (level_d >= LVL_W'(AFULL_TH));
`ifdef SYNC_FIFO_FWFT_EN
    dout_vld_d = !empty_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      dout_vld_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      aempty_q   <= aempty_d;
      afull_q    <= afull_d;
      dout_vld_q <= dout_vld_d;
      err_q      <= err_d;
    end
  end

  assign ram_we_c = wr_acc_c && !bus.flush;
  assign ram_re_c = rd_acc_c && !bus.flush;

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .REG_RD (!FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_c),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .re    (ram_re_c),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign bus.dout         = ram_rdata;
  assign bus.dout_vld     = dout_vld_q;
  assign bus.level        = level_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table for fill/drain plus queue-based scoreboard sequences.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_if #(.DWIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .DWIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb_q [$];
  logic [31:0] exp_dout;
  logic        exp_vld, exp_ovf, exp_udf;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    int          exp_level;
    logic        exp_full;
    logic        exp_af;
    logic        exp_ovf;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_dout = '0;
    exp_vld  = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  task automatic check_all();
    int lvl;
    lvl = sb_q.size();
    chk("level",        32'(bus.level),        32'(lvl));
    chk("empty",        32'(bus.empty),        32'(lvl == 0));
    chk("full",         32'(bus.full),         32'(lvl == DEPTH));
    chk("almost_empty", 32'(bus.almost_empty), 32'(lvl <= 2));
    chk("almost_full",  32'(bus.almost_full),  32'(lvl >= 14));
    chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
    chk("underflow",    32'(bus.underflow),    32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("dout_vld", 32'(bus.dout_vld), 32'(lvl != 0));
    if (lvl != 0) chk("dout", bus.dout, sb_q[0]);
`else
    chk("dout_vld", 32'(bus.dout_vld), 32'(exp_vld));
    chk("dout",     bus.dout,          exp_dout);
`endif
  endtask

  // Drive one cycle, advance the queue model on the edge, then compare everything.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd,
                      input logic fl, input logic clr);
    logic wr_acc, rd_acc;
    bus.wr_en   = wr;
    bus.din     = d;
    bus.rd_en   = rd;
    bus.flush   = fl;
    bus.clr_err = clr;
    wr_acc = wr && (sb_q.size() != DEPTH);
    rd_acc = rd && (sb_q.size() != 0);
    @(posedge clk);
    if (clr) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    exp_vld = 1'b0;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (rd_acc) begin
        exp_dout = sb_q.pop_front();
        exp_vld  = 1'b1;
      end
      if (wr_acc) sb_q.push_back(d);
      if (wr && !wr_acc) exp_ovf = 1'b1;
      if (rd && !rd_acc) exp_udf = 1'b1;
    end
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    check_all();
  endtask

  initial begin
    int max_lvl;

    for (int i = 0; i < 15; i++)
      vecs[i] = '{1'b1, 32'(32'h11 + i), 1'b0, i + 1, 1'b0, (i + 1 >= 14), 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h20, 1'b0, 16, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 32'hAA, 1'b0, 16, 1'b1, 1'b1, 1'b1, 32'h0};
    for (int i = 0; i < 16; i++)
      vecs[17 + i] = '{1'b0, 32'h0, 1'b1, 15 - i, 1'b0, (15 - i >= 14), 1'b1,
                       (i < 15) ? 32'(32'h11 + i) : 32'h20};

    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.din     = '0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill to full, overflow attempt, then drain in order.
    for (int i = 0; i < 33; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0, 1'b0);
      chk("vec_level",    32'(bus.level),       32'(vecs[i].exp_level));
      chk("vec_full",     32'(bus.full),        32'(vecs[i].exp_full));
      chk("vec_afull",    32'(bus.almost_full), 32'(vecs[i].exp_af));
      chk("vec_overflow", 32'(bus.overflow),    32'(vecs[i].exp_ovf));
`ifndef SYNC_FIFO_FWFT_EN
      if (vecs[i].rd) chk("vec_dout", bus.dout, vecs[i].exp_dout);
`endif
    end

    // Simultaneous read/write at full: write rejected, then both accepted.
    for (int i = 0; i < 16; i++) step(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBB, 1'b1, 1'b0, 1'b0);
    chk("full_rw_level", 32'(bus.level), 32'd15);
    chk("full_rw_full",  32'(bus.full),  32'd0);
    step(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    chk("both_acc_level", 32'(bus.level), 32'd15);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    // Streaming 40 words with concurrent reads; pointers wrap twice.
    max_lvl = 0;
    for (int i = 0; i <= 40; i++) begin
      step(i < 40, 32'(32'h200 + i), i > 0, 1'b0, 1'b0);
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    chk("stream_max_level_le2", 32'(max_lvl <= 2), 32'd1);

    // Underflow, clr_err collision (set wins), then clr_err alone.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("udf_set", 32'(bus.underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_dout_hold", bus.dout, 32'h227);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("udf_set_wins", 32'(bus.underflow), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("udf_cleared", 32'(bus.underflow), 32'd0);

    // Flush at level 5 together with a write; the written word is discarded.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3FF, 1'b0, 1'b1, 1'b0);
    chk("flush_level",    32'(bus.level),    32'd0);
    chk("flush_empty",    32'(bus.empty),    32'd1);
    chk("flush_dout_vld", 32'(bus.dout_vld), 32'd0);
    chk("flush_ovf",      32'(bus.overflow), 32'd0);
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_flush_dout", bus.dout, 32'h77);
`endif

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midrst_level", 32'(bus.level), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
